dsp_rx_sequencer: RTL and testbench

DSP_RX_SEQUENCER -- requirements
Module: dsp_rx_sequencer

---
 rtl/dsp_rx_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_dsp_rx_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_rx_sequencer.sv
// dsp_rx_sequencer: timed receive-burst sequencer.
// Commands of the form {time, word} are written over the settings bus into a small queue.
// Each command starts a burst of DSP samples, either at a given master_time or immediately.
// Bursts may chain into the next queued command without a gap.
// Optional build macro DSP_RX_SEQ_LATE_ERR_EN traps commands whose start time has already passed.
module dsp_rx_sequencer #(
  parameter int BASE        = 176,
  parameter int QDEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] master_time,
  input  logic [31:0] sample,
  input  logic        strobe,
  output logic        run,
  output logic [33:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] burst_time,
  output logic [7:0]  status
);

  localparam int DEPTH = 2 ** QDEPTH_LOG2;
  localparam int CW    = QDEPTH_LOG2 + 1;
  localparam logic [7:0] ADDR_TIME  = 8'(BASE);
  localparam logic [7:0] ADDR_WORD  = 8'(BASE + 1);
  localparam logic [7:0] ADDR_CLEAR = 8'(BASE + 2);
  localparam logic [QDEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [29:0] CNT_ONE = 30'd1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_TIME   = 3'd1,
    RUNNING     = 3'd2,
    ERR_OVERRUN = 3'd3,
    ERR_LATE    = 3'd4,
    ERR_CHAIN   = 3'd5
  } state_t;

  state_t state, state_n;

  logic [31:0]            pend_time;
  logic [63:0]            q_mem [DEPTH];
  logic [QDEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]          q_count;
  logic [2:0]             q_count3;
  logic                   cmd_ovf, err;
  logic                   time_wr, word_wr, clear_wr, q_full, q_nonempty, do_push;
  logic [63:0]            head;
  logic [31:0]            head_time;
  logic                   head_now, head_chain;
  logic [29:0]            head_num;
  logic [29:0]            cur_num, sample_cnt, cnt_n;
  logic                   cur_chain, sof_pend;
  logic                   pop, do_write, set_eof, load_head, start_burst;

  assign time_wr    = set_stb && (set_addr == ADDR_TIME);
  assign word_wr    = set_stb && (set_addr == ADDR_WORD);
  assign clear_wr   = set_stb && (set_addr == ADDR_CLEAR);
  assign q_full     = (q_count == CW'(DEPTH));
  assign q_nonempty = (q_count != '0);
  assign do_push    = word_wr && !clear_wr && !q_full;

  assign head       = q_mem[rd_ptr];
  assign head_time  = head[63:32];
  assign head_now   = head[31];
  assign head_chain = head[30];
  assign head_num   = head[29:0];

`ifdef DSP_RX_SEQ_LATE_ERR_EN
  logic [31:0] late_diff;
  logic        is_late;
  assign late_diff = master_time - head_time;
  assign is_late   = !late_diff[31] && (late_diff != '0);
`endif

  assign run      = (state == RUNNING);
  assign err      = (state == ERR_OVERRUN) || (state == ERR_LATE) || (state == ERR_CHAIN);
  assign q_count3 = 3'(q_count);
  assign status   = {state, q_count3, cmd_ovf, err};

  // Command storage; pointers and occupancy live in the control block below.
  always_ff @(posedge clk) begin
    if (do_push) q_mem[wr_ptr] <= {pend_time, set_data};
  end

  // Queue pointers, occupancy, overflow flag and the pending start time register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_count   <= '0;
      cmd_ovf   <= 1'b0;
      pend_time <= '0;
    end else begin
      if (time_wr) pend_time <= set_data;
      if (clear_wr) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        q_count <= '0;
        cmd_ovf <= 1'b0;
      end else begin
        if (word_wr && q_full) cmd_ovf <= 1'b1;
        if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        q_count <= q_count + CW'(do_push) - CW'(pop);
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, queue pop and sample write decisions; a clear overrides everything.
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    do_write    = 1'b0;
    set_eof     = 1'b0;
    load_head   = 1'b0;
    start_burst = 1'b0;
    cnt_n       = sample_cnt;
    if (clear_wr) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (q_nonempty) state_n = WAIT_TIME;
        end
        WAIT_TIME: begin
          if (head_now || (master_time == head_time)) begin
            pop         = 1'b1;
            load_head   = 1'b1;
            start_burst = 1'b1;
            cnt_n       = '0;
            state_n     = RUNNING;
          end
`ifdef DSP_RX_SEQ_LATE_ERR_EN
          else if (is_late) begin
            pop     = 1'b1;
            state_n = ERR_LATE;
          end
`endif
        end
        RUNNING: begin
          if (strobe) begin
            if (!wr_ready) begin
              state_n = ERR_OVERRUN;
            end else begin
              do_write = 1'b1;
              cnt_n    = sample_cnt + CNT_ONE;
              if ((cur_num != '0) && (cnt_n == cur_num)) begin
                if (cur_chain && q_nonempty) begin
                  pop       = 1'b1;
                  load_head = 1'b1;
                  cnt_n     = '0;
                end else begin
                  set_eof = 1'b1;
                  state_n = cur_chain ? ERR_CHAIN : IDLE;
                end
              end
            end
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // Burst bookkeeping and the registered write port toward the downstream FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      cur_num    <= '0;
      cur_chain  <= 1'b0;
      sof_pend   <= 1'b0;
      burst_time <= '0;
      wr_valid   <= 1'b0;
      wr_data    <= '0;
    end else begin
      sample_cnt <= cnt_n;
      wr_valid   <= do_write;
      if (load_head) begin
        cur_num   <= head_num;
        cur_chain <= head_chain;
      end
      if (start_burst) begin
        burst_time <= master_time;
        sof_pend   <= 1'b1;
      end else if (do_write) begin
        sof_pend <= 1'b0;
      end
      if (do_write) wr_data <= {sof_pend, set_eof, sample};
    end
  end

endmodule

// File: tb/tb_dsp_rx_sequencer.sv
// tb_dsp_rx_sequencer: scoreboard bench for dsp_rx_sequencer.
// Expected FIFO words are queued as strobes are driven and compared as wr_valid appears.
module tb_dsp_rx_sequencer;

  localparam int BASE = 176;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] master_time;
  logic [31:0] sample;
  logic        strobe;
  logic        run;
  logic [33:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] burst_time;
  logic [7:0]  status;

  int vectors     = 0;
  int miscompares = 0;
  logic [33:0] exp_q[$];

  dsp_rx_sequencer #(.BASE(BASE), .QDEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .master_time(master_time), .sample(sample), .strobe(strobe), .run(run),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .burst_time(burst_time), .status(status)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: outputs are inspected 1 time unit after the edge, then master_time advances.
  task automatic step();
    logic [33:0] exp;
    @(posedge clk);
    #1;
    master_time = master_time + 1;
    if (wr_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("wr_valid_extra", 64'(wr_valid), 64'd0);
      end else begin
        exp = exp_q.pop_front();
        checkOutput("wr_data", 64'(wr_data), 64'(exp));
      end
    end
  endtask

  task automatic applyStimulus(input int offset, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = 8'(BASE + offset);
    set_data = data;
    strobe   = 1'b0;
    step();
    set_stb  = 1'b0;
  endtask

  task automatic drive_strobe(input logic stb, input logic ready, input logic expect_wr,
                              input logic sof, input logic eof);
    strobe   = stb;
    wr_ready = ready;
    sample   = $urandom;
    if (expect_wr) exp_q.push_back({sof, eof, sample});
    step();
  endtask

  task automatic wait_run(input string tag);
    int waited;
    waited = 0;
    while (!run && waited < 10) begin
      drive_strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      waited++;
    end
    checkOutput(tag, 64'(run), 64'd1);
  endtask

  initial begin
    logic [31:0] m;
    rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    master_time = '0; sample = '0; strobe = 1'b0; wr_ready = 1'b1;
    step();
    step();
    checkOutput("rst_run", 64'(run), 64'd0);
    checkOutput("rst_wr_valid", 64'(wr_valid), 64'd0);
    checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
    checkOutput("rst_burst_time", 64'(burst_time), 64'd0);
    checkOutput("rst_status", 64'(status), 64'd0);
    rst = 1'b0;
    step();

    // Timed burst of 4 samples at master_time 1000.
    applyStimulus(0, 32'd1000);
    applyStimulus(1, 32'h0000_0004);
    checkOutput("t1_push_status", 64'(status), 64'h04);
    step();
    checkOutput("t1_wait_status", 64'(status), 64'h24);
    master_time = 32'd995;
    repeat (12) begin
      m = master_time;
      drive_strobe(1'b1, 1'b1, (m >= 1001) && (m <= 1004), m == 1001, m == 1004);
      checkOutput("t1_run", 64'(run), 64'((master_time >= 1001) && (master_time <= 1004)));
    end
    checkOutput("t1_burst_time", 64'(burst_time), 64'd1000);
    checkOutput("t1_end_status", 64'(status), 64'h00);
    checkOutput("t1_sb_pending", 64'(exp_q.size()), 64'd0);

    // Chained burst: 3 samples then a 2-sample continuation.
    applyStimulus(0, 32'd2000);
    applyStimulus(1, 32'h4000_0003);
    applyStimulus(1, 32'h8000_0002);
    master_time = 32'd1995;
    repeat (13) begin
      m = master_time;
      drive_strobe(1'b1, 1'b1, (m >= 2001) && (m <= 2005), m == 2001, m == 2005);
      checkOutput("t2_run", 64'(run), 64'((master_time >= 2001) && (master_time <= 2005)));
    end
    checkOutput("t2_burst_time", 64'(burst_time), 64'd2000);
    checkOutput("t2_end_status", 64'(status), 64'h00);
    checkOutput("t2_sb_pending", 64'(exp_q.size()), 64'd0);

    // Continuous burst with the FIFO full on the 10th sample.
    applyStimulus(1, 32'h8000_0000);
    wait_run("t3_run_start");
    for (int k = 1; k <= 10; k++) begin
      if (k < 10) begin
        drive_strobe(1'b1, 1'b1, 1'b1, k == 1, 1'b0);
        checkOutput("t3_run", 64'(run), 64'd1);
      end else begin
        drive_strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    checkOutput("t3_run_low", 64'(run), 64'd0);
    checkOutput("t3_ovr_status", 64'(status), 64'h61);
    repeat (3) begin
      drive_strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t3_err_held", 64'(status[0]), 64'd1);
    end
    applyStimulus(2, 32'd0);
    checkOutput("t3_clr_status", 64'(status), 64'h00);
    checkOutput("t3_clr_run", 64'(run), 64'd0);
    checkOutput("t3_sb_pending", 64'(exp_q.size()), 64'd0);

    // Queue overflow with future-timed commands, then clear.
    applyStimulus(0, master_time + 32'd10000);
    repeat (5) applyStimulus(1, 32'h0000_0008);
    checkOutput("t4_qcount", 64'(status[4:2]), 64'd4);
    checkOutput("t4_ovf", 64'(status[1]), 64'd1);
    applyStimulus(2, 32'd0);
    checkOutput("t4_clr_qcount", 64'(status[4:2]), 64'd0);
    checkOutput("t4_clr_ovf", 64'(status[1]), 64'd0);

    // Command whose time is already in the past.
    master_time = 32'd98;
    applyStimulus(0, 32'd50);
    applyStimulus(1, 32'h0000_0004);
    repeat (4) begin
      drive_strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t5_run", 64'(run), 64'd0);
    end
`ifdef DSP_RX_SEQ_LATE_ERR_EN
    checkOutput("t5_late_status", 64'(status), 64'h81);
`else
    checkOutput("t5_wait_status", 64'(status), 64'h24);
`endif
    applyStimulus(2, 32'd0);
    checkOutput("t5_clr_status", 64'(status), 64'h00);

    // Reset in the middle of a continuous burst.
    applyStimulus(1, 32'h8000_0000);
    wait_run("t6_run_start");
    for (int k = 1; k <= 3; k++) drive_strobe(1'b1, 1'b1, 1'b1, k == 1, 1'b0);
    rst = 1'b1;
    drive_strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_run", 64'(run), 64'd0);
    checkOutput("t6_wr_valid", 64'(wr_valid), 64'd0);
    checkOutput("t6_wr_data", 64'(wr_data), 64'd0);
    checkOutput("t6_burst_time", 64'(burst_time), 64'd0);
    checkOutput("t6_status", 64'(status), 64'd0);
    rst = 1'b0;
    repeat (3) begin
      drive_strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t6_post_wr_valid", 64'(wr_valid), 64'd0);
    end
    checkOutput("t6_sb_pending", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
